// File: rtl/alu_chk_pkg.sv
// Shared definitions for the ALU response checker: sel encodings, widths and FSM states.
package alu_chk_pkg;

  localparam int OPND_W = 4;
  localparam int VEC_W  = 2 + 2 * OPND_W;

  localparam logic [1:0] SEL_ADD  = 2'b00;
  localparam logic [1:0] SEL_SUB  = 2'b01;
  localparam logic [1:0] SEL_NEG  = 2'b10;
  localparam logic [1:0] SEL_PASS = 2'b11;

  // Most negative operand; the only value whose negation overflows
  localparam logic signed [OPND_W-1:0] OPND_MIN = {1'b1, {(OPND_W-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_golden_model.sv
// Combinational reference for the 4-bit signed ALU: expected result and overflow flag.
module alu_golden_model
  import alu_chk_pkg::*;
(
  input  logic        [1:0]        sel,
  input  logic signed [OPND_W-1:0] a,
  input  logic signed [OPND_W-1:0] b,
  output logic signed [OPND_W-1:0] exp_q,
  output logic                     exp_ov
);

  logic signed [OPND_W:0] a_x;
  logic signed [OPND_W:0] b_x;
  logic signed [OPND_W:0] res;

  assign a_x = {a[OPND_W-1], a};
  assign b_x = {b[OPND_W-1], b};

  // Overflow is judged on the sign bit of the 4-bit result, not the 5-bit sum
  always_comb begin
    res    = '0;
    exp_ov = 1'b0;
    case (sel)
      SEL_ADD: begin
        res    = a_x + b_x;
        exp_ov = (a[OPND_W-1] == b[OPND_W-1]) && (res[OPND_W-1] != a[OPND_W-1]);
      end
      SEL_SUB: begin
        res    = a_x - b_x;
        exp_ov = (a[OPND_W-1] != b[OPND_W-1]) && (res[OPND_W-1] != a[OPND_W-1]);
      end
      SEL_NEG: begin
        res    = -a_x;
        exp_ov = (a == OPND_MIN);
      end
      default: begin
        res    = a_x;
        exp_ov = 1'b0;
      end
    endcase
    exp_q = res[OPND_W-1:0];
  end

endmodule

// File: rtl/alu_response_checker.sv
// Self-checking response monitor for the 4-bit signed ALU (IDLE/RUN/DONE run control).
// Define ALU_CHK_STOP_ON_ERR_EN to end a run on its first mismatch.
module alu_response_checker
  import alu_chk_pkg::*;
#(
  parameter int NUM_VECTORS = 1024,
  parameter int CNT_W       = 11
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     vec_valid,
  input  logic        [1:0]        sel,
  input  logic signed [OPND_W-1:0] a,
  input  logic signed [OPND_W-1:0] b,
  input  logic signed [OPND_W-1:0] q,
  input  logic                     overflow,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic        [CNT_W-1:0]  vec_count,
  output logic        [CNT_W-1:0]  err_count,
  output logic                     first_err_valid,
  output logic        [VEC_W-1:0]  first_err_vec
);

  state_t                   state;
  state_t                   state_nxt;
  logic signed [OPND_W-1:0] exp_q;
  logic                     exp_ov;
  logic        [CNT_W:0]    pending;
  logic                     accept;
  logic                     clr;
  logic                     cnt_en;
  logic                     last_cnt;
  logic                     vld_p0;
  logic                     mis_p0;
  logic        [VEC_W-1:0]  vec_p0;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
    return (&x) ? x : x + CNT_W'(1);
  endfunction

  alu_golden_model u_golden (
    .sel    (sel),
    .a      (a),
    .b      (b),
    .exp_q  (exp_q),
    .exp_ov (exp_ov)
  );

  // A vector still in the compare register counts toward the limit, so no extra vector slips in
  assign pending  = {1'b0, vec_count} + {{CNT_W{1'b0}}, vld_p0};
  assign accept   = (state == ST_RUN) && vec_valid && (pending < (CNT_W+1)'(NUM_VECTORS));
  assign clr      = start && (state != ST_RUN);
  assign cnt_en   = (state == ST_RUN) && vld_p0;
  assign last_cnt = (vec_count == CNT_W'(NUM_VECTORS));
  assign pass     = (state == ST_DONE) && (err_count == '0);

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        busy = 1'b1;
        if (last_cnt) state_nxt = ST_DONE;
`ifdef ALU_CHK_STOP_ON_ERR_EN
        if (cnt_en && mis_p0) state_nxt = ST_DONE;
`endif
      end
      ST_DONE: begin
        done = 1'b1;
        if (start) state_nxt = ST_RUN;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // p0: sampled vector and its registered compare result
  always_ff @(posedge clk) begin
    if (accept) begin
      vec_p0 <= {sel, a, b};
      mis_p0 <= (q != exp_q) || (overflow != exp_ov);
    end
  end

  // p1: counters and first-error capture
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_IDLE;
      vld_p0          <= 1'b0;
      vec_count       <= '0;
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_vec   <= '0;
    end else begin
      state  <= state_nxt;
      vld_p0 <= accept;
      if (clr) begin
        vec_count       <= '0;
        err_count       <= '0;
        first_err_valid <= 1'b0;
        first_err_vec   <= '0;
      end else if (cnt_en) begin
        vec_count <= vec_count + CNT_W'(1);
        if (mis_p0) begin
          err_count <= sat_inc(err_count);
          if (!first_err_valid) begin
            first_err_valid <= 1'b1;
            first_err_vec   <= vec_p0;
          end
        end
      end
    end
  end

endmodule
